pipe_stage_skid: RTL

- Parametrised, elastic pipeline-stage register; successor to the fixed-field stage registers between F/D/E/M/W.
- Carries an arbitrary packed bundle of DATA_W bits (control plus datapath fields, concatenated by the instantiating stage).
- Adds valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, synchronous flush, bubble zeroing and a saturating stall counter.
- Sits between any two pipeline stages of the OTTER core.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_sat_counter.sv | 23 ++
 rtl/pipe_stage_skid.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline-stage register.
// The state encoding doubles as the occupancy count (EMPTY=0, ONE=1, TWO=2).
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } pipe_state_t;

    localparam int OCC_W = 2;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with enable.
// The count sticks at all-ones instead of wrapping.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: valid/ready handshake, two-entry skid buffer,
// synchronous flush, bubble zeroing and a saturating stall counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int CNT_W          = 16,
    parameter int ZERO_ON_BUBBLE = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occ,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_t       state;
    pipe_state_t       nextState;
    logic [DATA_W-1:0] mainData;
    logic [DATA_W-1:0] skidData;
    logic              accept;
    logic              drain;
    logic              loadMainIn;
    logic              loadMainSkid;
    logic              loadSkid;

    // Handshake flags come straight from registered state, so in_ready has no
    // combinational path from out_ready.
    assign in_ready  = (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        nextState    = state;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    loadMainIn = 1'b1;
                    nextState  = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    loadMainIn = 1'b1;
                end else if (accept) begin
                    loadSkid  = 1'b1;
                    nextState = ST_TWO;
                end else if (drain) begin
                    nextState = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (drain) begin
                    loadMainSkid = 1'b1;
                    nextState    = ST_ONE;
                end
            end
            default: nextState = ST_EMPTY;
        endcase
        // A redirect discards everything held plus whatever is being offered;
        // a bundle draining this cycle has already completed its handshake.
        if (flush) begin
            nextState    = ST_EMPTY;
            loadMainIn   = 1'b0;
            loadMainSkid = 1'b0;
            loadSkid     = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_EMPTY;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mainData <= '0;
            skidData <= '0;
        end else begin
            if (loadMainIn) begin
                mainData <= in_data;
            end else if (loadMainSkid) begin
                mainData <= skidData;
            end
            if (loadSkid) begin
                skidData <= in_data;
            end
        end
    end

    always_comb begin
        case (state)
            ST_ONE:  occ = 2'd1;
            ST_TWO:  occ = 2'd2;
            default: occ = 2'd0;
        endcase
    end

    // Zeroed bubbles keep write-enable style bits inert downstream.
    assign out_data = ((ZERO_ON_BUBBLE != 0) && !out_valid) ? '0 : mainData;

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) uStallCnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .en    (out_valid & ~out_ready),
        .count (stall_cnt)
    );

endmodule
